arrow_shot_ctrl: RTL and testbench
==================================

// Module: arrow_shot_ctrl
// PURPOSE
// - Drives the arrow head bitmap's pixel-address interface (offsetX, offsetY, InsideRectangle).
// - Owns the arrow shot lifecycle: launch from the player, rise once per frame, end on hit or ceiling.
// - Also flags the rope/shaft pixels under the head.
// - Sits between the VGA pixel counters / game logic and the 24x32 arrow head bitmap.
// PARAMETERS
// - ARROW_W      24   head bitmap width (px)
// - ARROW_H      32   head bitmap height (px)
// - PLAYER_W     32   player sprite width, used to centre the launch X
// - SCREEN_W     640  visible width; launch X clamped to SCREEN_W-ARROW_W
// - FLOOR_Y      448  launch row; head top-left Y at launch = FLOOR_Y-ARROW_H
// - CEILING_Y    16   minimum head top-left Y
// - SPEED        4    px the head rises per startOfFrame
// - SHAFT_X0     10   shaft left column, relative to head X
// - SHAFT_W      4    shaft width (px)
// - HOLD_FRAMES  30   frames held at ceiling (ARROW_STICKY_EN only)
// PORTS
// - clk              in   1   pixel clock
// - resetN           in   1   asynchronous active-low reset
// - startOfFrame     in   1   one-cycle pulse per frame
// - fire             in   1   shoot button, level; rising edge detected internally
// - hit              in   1   collision pulse (arrow vs ball)
// - playerX          in   11  player top-left X
// - pixelX           in   11  current scan X
// - pixelY           in   11  current scan Y
// - offsetX          out  11  pixelX - headX when inside the head rectangle, else 0
// - offsetY          out  11  pixelY - headY when inside the head rectangle, else 0
// - InsideRectangle  out  1   pixel is inside the head rectangle
// - shaftRequest     out  1   pixel is on the shaft
// - arrowActive      out  1   shot in flight (or stuck)
// - arrowTopY        out  11  current head top-left Y
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; arrowTopY=FLOOR_Y-ARROW_H; fire edge register=0.
// - FSM states: IDLE, FLY, STICK (STICK exists only with ARROW_STICKY_EN).
// - IDLE -> FLY: on a fire rising edge (fire=1, previous-cycle fire=0).
//   - Latch headX=min(playerX+(PLAYER_W-ARROW_W)/2, SCREEN_W-ARROW_W).
//   - Load headY=FLOOR_Y-ARROW_H.
// - A fire edge in FLY or STICK is ignored; there is no queueing.
// - FLY, per cycle, priority hit > startOfFrame:
//   - hit=1: go to IDLE next cycle; headY reloads to FLOOR_Y-ARROW_H.
//   - Else on startOfFrame with headY-CEILING_Y <= SPEED: headY=CEILING_Y; go to STICK, or to IDLE without the macro.
//   - Else on startOfFrame: headY -= SPEED.
// - STICK: frame counter loaded with HOLD_FRAMES on entry, decremented per startOfFrame.
//   - At 0, or on hit, go to IDLE.
// - Compare arithmetic is 11-bit unsigned, written so it never underflows. Shaft compare uses headX+SHAFT_X0.
// - arrowActive=1 in FLY and STICK; it is registered and follows the state with one cycle of latency.
// - Address path is registered, 1-cycle latency from pixelX/pixelY. The bitmap adds 1 more, so 2 cycles total to RGB.
//   - inside = active && headX<=pixelX<headX+ARROW_W && headY<=pixelY<headY+ARROW_H.
//   - shaft  = active && headX+SHAFT_X0<=pixelX<headX+SHAFT_X0+SHAFT_W && headY+ARROW_H<=pixelY<FLOOR_Y.
//   - Offsets forced to 0 when not inside, so the bitmap index stays in range.
// - headY updates only on startOfFrame or a state change, so there is no tearing within a frame.
// - Launch and hit take effect on address outputs from the cycle after the state change.
// - Reset asserted mid-flight: immediate return to reset values; no partial-shot residue.
// CONFIGURATION
// - ARROW_STICKY_EN defined: reaching the ceiling enters STICK for HOLD_FRAMES frames. The arrow stays drawn and can still hit balls.
// - ARROW_STICKY_EN undefined: reaching the ceiling goes straight to IDLE. STICK and the hold counter are not built.
// TESTING
// - Launch: reset, playerX=100, fire 0->1 -> arrowActive=1 two cycles later; headX=104, arrowTopY=416.
// - Flight: 10 startOfFrame pulses in FLY -> arrowTopY=376. A held fire level causes no relaunch.
// - Addressing: head at (104,376), pixel (110,380) -> next cycle InsideRectangle=1, offsetX=6, offsetY=4.
//   - Pixel (128,380) -> InsideRectangle=0, offsets 0.
//   - Pixel (115,420) -> shaftRequest=1.
// - Hit on the same cycle as startOfFrame -> IDLE; arrowTopY=416; no decrement applied.
// - Ceiling, headY=18: next startOfFrame clamps to 16.
//   - Without macro: IDLE.
//   - With ARROW_STICKY_EN: 30 frames held, then IDLE.
// - Clamp and reset: playerX=630 -> headX=616. resetN low mid-flight -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/arrow_shot_ctrl.sv
// Arrow shot controller: launch, per-frame rise, hit/ceiling end, registered head/shaft addressing.
// Optional ARROW_STICKY_EN: the head holds at the ceiling for HOLD_FRAMES frames before retiring.
module arrow_shot_ctrl #(
    parameter int unsigned ARROW_W     = 24,
    parameter int unsigned ARROW_H     = 32,
    parameter int unsigned PLAYER_W    = 32,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned FLOOR_Y     = 448,
    parameter int unsigned CEILING_Y   = 16,
    parameter int unsigned SPEED       = 4,
    parameter int unsigned SHAFT_X0    = 10,
    parameter int unsigned SHAFT_W     = 4,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic        hit,
    input  logic [10:0] playerX,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        shaftRequest,
    output logic        arrowActive,
    output logic [10:0] arrowTopY
);

    localparam logic [10:0] LaunchY   = 11'(FLOOR_Y - ARROW_H);
    localparam logic [10:0] FloorY    = 11'(FLOOR_Y);
    localparam logic [10:0] CeilY     = 11'(CEILING_Y);
    localparam logic [10:0] ClampY    = 11'(CEILING_Y + SPEED);
    localparam logic [10:0] Speed     = 11'(SPEED);
    localparam logic [10:0] ArrowW    = 11'(ARROW_W);
    localparam logic [10:0] ArrowH    = 11'(ARROW_H);
    localparam logic [10:0] ShaftX0   = 11'(SHAFT_X0);
    localparam logic [10:0] ShaftW    = 11'(SHAFT_W);
    localparam logic [11:0] MaxX      = 12'(SCREEN_W - ARROW_W);
    localparam logic [11:0] CentreOff = 12'((PLAYER_W - ARROW_W) / 2);

`ifdef ARROW_STICKY_EN
    localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_FRAMES);
    typedef enum logic [1:0] {StIdle, StFly, StStick} state_e;
    logic [HoldW-1:0] hold_q, hold_d;
`else
    typedef enum logic [1:0] {StIdle, StFly} state_e;
`endif

    state_e      state_q, state_d;
    logic        fire_q;
    logic [10:0] head_x_q, head_x_d;
    logic [10:0] head_y_q, head_y_d;
    logic        active_q;
    logic        inside_q, inside_d;
    logic        shaft_q, shaft_d;
    logic [10:0] offset_x_q, offset_x_d;
    logic [10:0] offset_y_q, offset_y_d;

    logic        fire_rise;
    logic        active;
    logic [11:0] launch_x;
    logic [10:0] launch_x_clamped;
    logic [10:0] shaft_x;

    assign fire_rise        = fire & ~fire_q;
    // 12-bit sum so a player near the right edge cannot wrap before the clamp
    assign launch_x         = {1'b0, playerX} + CentreOff;
    assign launch_x_clamped = (launch_x > MaxX) ? MaxX[10:0] : launch_x[10:0];

    always_comb begin
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
`ifdef ARROW_STICKY_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            StIdle: begin
                if (fire_rise) begin
                    state_d  = StFly;
                    head_x_d = launch_x_clamped;
                    head_y_d = LaunchY;
                end
            end
            StFly: begin
                if (hit) begin
                    state_d  = StIdle;
                    head_y_d = LaunchY;
                end else if (startOfFrame) begin
                    // headY - CEILING_Y <= SPEED, rearranged to avoid underflow
                    if (head_y_q <= ClampY) begin
                        head_y_d = CeilY;
`ifdef ARROW_STICKY_EN
                        state_d  = StStick;
                        hold_d   = HoldInit;
`else
                        state_d  = StIdle;
`endif
                    end else begin
                        head_y_d = head_y_q - Speed;
                    end
                end
            end
`ifdef ARROW_STICKY_EN
            StStick: begin
                if (hit) begin
                    state_d  = StIdle;
                    head_y_d = LaunchY;
                end else if (hold_q == '0) begin
                    state_d = StIdle;
                end else if (startOfFrame) begin
                    hold_d = hold_q - 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign active  = (state_q != StIdle);
    assign shaft_x = head_x_q + ShaftX0;

    always_comb begin
        inside_d = active
                && (pixelX >= head_x_q) && (pixelX < head_x_q + ArrowW)
                && (pixelY >= head_y_q) && (pixelY < head_y_q + ArrowH);
        shaft_d  = active
                && (pixelX >= shaft_x) && (pixelX < shaft_x + ShaftW)
                && (pixelY >= head_y_q + ArrowH) && (pixelY < FloorY);
        offset_x_d = inside_d ? (pixelX - head_x_q) : '0;
        offset_y_d = inside_d ? (pixelY - head_y_q) : '0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            fire_q     <= 1'b0;
            head_x_q   <= '0;
            head_y_q   <= LaunchY;
            active_q   <= 1'b0;
            inside_q   <= 1'b0;
            shaft_q    <= 1'b0;
            offset_x_q <= '0;
            offset_y_q <= '0;
        end else begin
            state_q    <= state_d;
            fire_q     <= fire;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            active_q   <= active;
            inside_q   <= inside_d;
            shaft_q    <= shaft_d;
            offset_x_q <= offset_x_d;
            offset_y_q <= offset_y_d;
        end
    end

`ifdef ARROW_STICKY_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign InsideRectangle = inside_q;
    assign shaftRequest    = shaft_q;
    assign arrowActive     = active_q;
    assign arrowTopY       = head_y_q;

endmodule

// File: tb/tb_arrow_shot_ctrl.sv
// Directed bench for arrow_shot_ctrl: launch, flight, addressing, hit, ceiling, clamp, async reset.
module tb_arrow_shot_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        fire;
    logic        hit;
    logic [10:0] playerX;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        shaftRequest;
    logic        arrowActive;
    logic [10:0] arrowTopY;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    arrow_shot_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .fire            (fire),
        .hit             (hit),
        .playerX         (playerX),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .shaftRequest    (shaftRequest),
        .arrowActive     (arrowActive),
        .arrowTopY       (arrowTopY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic probe(input logic [10:0] x, input logic [10:0] y);
        pixelX = x;
        pixelY = y;
        step();
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        fire         = 1'b0;
        hit          = 1'b0;
        playerX      = 11'd100;
        pixelX       = '0;
        pixelY       = '0;
        #12;
        check("reset_active", 32'(arrowActive), 0);
        check("reset_topy", 32'(arrowTopY), 416);
        check("reset_inside", 32'(InsideRectangle), 0);
        step(2);
        resetN = 1'b1;
        step(2);

        // Launch from playerX=100
        fire = 1'b1;
        step();
        check("launch_topy", 32'(arrowTopY), 416);
        check("launch_active_lat1", 32'(arrowActive), 0);
        step();
        check("launch_active_lat2", 32'(arrowActive), 1);

        // Fire held high throughout flight
        for (int i = 0; i < 10; i++) frame();
        check("flight_topy", 32'(arrowTopY), 376);

        probe(11'd110, 11'd380);
        check("addr_inside", 32'(InsideRectangle), 1);
        check("addr_offx", 32'(offsetX), 6);
        check("addr_offy", 32'(offsetY), 4);
        probe(11'd128, 11'd380);
        check("addr_right_edge_inside", 32'(InsideRectangle), 0);
        check("addr_right_edge_offx", 32'(offsetX), 0);
        check("addr_right_edge_offy", 32'(offsetY), 0);
        probe(11'd104, 11'd376);
        check("addr_corner_inside", 32'(InsideRectangle), 1);
        probe(11'd115, 11'd420);
        check("shaft_on", 32'(shaftRequest), 1);
        check("shaft_not_head", 32'(InsideRectangle), 0);
        probe(11'd118, 11'd420);
        check("shaft_right_edge", 32'(shaftRequest), 0);
        probe(11'd115, 11'd448);
        check("shaft_floor", 32'(shaftRequest), 0);

        // Hit coincident with startOfFrame: hit wins, no decrement
        pixelX       = 11'd110;
        pixelY       = 11'd380;
        hit          = 1'b1;
        startOfFrame = 1'b1;
        step();
        hit          = 1'b0;
        startOfFrame = 1'b0;
        check("hit_topy", 32'(arrowTopY), 416);
        step();
        check("hit_active", 32'(arrowActive), 0);
        check("hit_inside", 32'(InsideRectangle), 0);
        step(3);
        check("held_fire_no_relaunch", 32'(arrowActive), 0);

        // Ceiling run
        fire = 1'b0;
        step();
        fire = 1'b1;
        step(2);
        check("relaunch_active", 32'(arrowActive), 1);
        for (int i = 0; i < 99; i++) frame();
        check("near_ceiling_topy", 32'(arrowTopY), 20);
        frame();
        check("ceiling_clamp", 32'(arrowTopY), 16);
`ifdef ARROW_STICKY_EN
        step();
        check("stick_active", 32'(arrowActive), 1);
        for (int i = 0; i < 29; i++) frame();
        step(2);
        check("stick_still_held", 32'(arrowActive), 1);
        frame();
        step(2);
        check("stick_release", 32'(arrowActive), 0);
`else
        step();
        check("ceiling_idle", 32'(arrowActive), 0);
`endif

        // Launch X clamp at the right edge
        fire    = 1'b0;
        playerX = 11'd630;
        step();
        fire = 1'b1;
        step(2);
        probe(11'd616, 11'd416);
        check("clamp_inside", 32'(InsideRectangle), 1);
        check("clamp_offx", 32'(offsetX), 0);
        probe(11'd620, 11'd420);
        check("clamp_offx4", 32'(offsetX), 4);
        check("clamp_offy4", 32'(offsetY), 4);
        probe(11'd615, 11'd420);
        check("clamp_left_out", 32'(InsideRectangle), 0);
        probe(11'd620, 11'd420);
        frame();
        frame();
        check("pre_reset_topy", 32'(arrowTopY), 408);

        // Asynchronous reset mid-flight, away from any clock edge
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("async_rst_active", 32'(arrowActive), 0);
        check("async_rst_inside", 32'(InsideRectangle), 0);
        check("async_rst_offx", 32'(offsetX), 0);
        check("async_rst_topy", 32'(arrowTopY), 416);
        fire = 1'b0;
        step(2);
        resetN = 1'b1;
        step(3);
        check("post_reset_idle", 32'(arrowActive), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
